// File: rtl/uart_pkg.sv
// uart_pkg: frame constants and FSM encoding shared by the
// UART transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_piso.sv
// tx_piso: parallel-in serial-out shift register, LSB first.
// nxt exposes the bit that becomes LSB after the next shift.
module tx_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         lsb,
  output logic         nxt
);

  logic [W-1:0] q;
  logic [W-1:0] q_sh;

  assign q_sh = q >> 1;
  assign lsb  = q[0];
  assign nxt  = q_sh[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= q_sh;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start + data (LSB first) + parity + stop.
// tx_out is registered and updated one edge ahead of each bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int BW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [15:0] BAUD_LAST =
    16'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST =
    BW'(DATA_WIDTH - 1);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  tx_state_t     state;
  logic [15:0]   baud_cnt;
  logic [BW-1:0] bit_cnt;
  logic          parity;
  logic          tx_q;
  logic          done_q;
  logic          accept;
  logic          wrap;
  logic          shift;
  logic          sr_lsb;
  logic          sr_nxt;

  assign accept = (state == IDLE) && tx_start;
  assign wrap   = (state != IDLE) && (baud_cnt == BAUD_LAST);
  assign shift  = wrap && (state == DATA);

  tx_piso #(
    .W(DATA_WIDTH)
  ) u_piso (
    .clk  (clk),
    .rstn (rstn),
    .load (accept),
    .shift(shift),
    .din  (tx_data),
    .lsb  (sr_lsb),
    .nxt  (sr_nxt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      parity   <= 1'b0;
      tx_q     <= IDLE_LEVEL;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE || wrap) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
      unique case (state)
        IDLE: begin
          if (tx_start) begin
            state   <= START;
            tx_q    <= START_BIT;
            parity  <= (^tx_data) ^ PAR_ODD;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (wrap) begin
            state <= DATA;
            tx_q  <= sr_lsb;
          end
        end
        DATA: begin
          if (wrap) begin
            if (bit_cnt == BIT_LAST) begin
              state   <= PARITY;
              tx_q    <= parity;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx_q    <= sr_nxt;
            end
          end
        end
        PARITY: begin
          if (wrap) begin
            state <= STOP;
            tx_q  <= STOP_BIT;
          end
        end
        STOP: begin
          if (wrap) begin
            state  <= IDLE;
            tx_q   <= IDLE_LEVEL;
            done_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= IDLE_LEVEL;
        end
      endcase
    end
  end

  assign tx_out  = tx_q;
  assign tx_busy = (state != IDLE);
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitters (even/4, odd/4, even/1) checked
// by per-DUT frame monitors against a queue of expected frames.
module tb_uart_tx;

  logic       clk;
  logic       rstn;
  logic [2:0] start_w;
  logic [7:0] data_w [3];
  logic [2:0] tx_out_w;
  logic [2:0] busy_w;
  logic [2:0] done_w;

  int n_vec = 0;
  int n_bad = 0;

  logic [10:0] sb0[$];
  logic [10:0] sb1[$];
  logic [10:0] sb2[$];

  typedef struct {
    int         k;
    logic [7:0] d;
    logic       p;
  } vec_t;

  vec_t tbl [10];

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_ODD(0)) dut_e (
    .clk(clk), .rstn(rstn), .tx_start(start_w[0]),
    .tx_data(data_w[0]), .tx_out(tx_out_w[0]),
    .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_ODD(1)) dut_o (
    .clk(clk), .rstn(rstn), .tx_start(start_w[1]),
    .tx_data(data_w[1]), .tx_out(tx_out_w[1]),
    .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_ODD(0)) dut_1 (
    .clk(clk), .rstn(rstn), .tx_start(start_w[2]),
    .tx_data(data_w[2]), .tx_out(tx_out_w[2]),
    .tx_busy(busy_w[2]), .tx_done(done_w[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d,
                                        input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic sb_push(input int k, input logic [10:0] v);
    case (k)
      0: sb0.push_back(v);
      1: sb1.push_back(v);
      default: sb2.push_back(v);
    endcase
  endtask

  function automatic int sb_size(input int k);
    case (k)
      0: return sb0.size();
      1: return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  task automatic sb_pop(input int k, output logic [10:0] v);
    case (k)
      0: v = sb0.pop_front();
      1: v = sb1.pop_front();
      default: v = sb2.pop_front();
    endcase
  endtask

  task automatic mon(input int k, input int cpb);
    logic [10:0] got;
    logic [10:0] exp;
    bit stable;
    bit abort;
    bit done_low;
    done_low = 1'b0;
    forever begin
      @(negedge clk);
      if (done_low) begin
        chk($sformatf("done_pulse%0d", k), 32'(done_w[k]), 0);
        done_low = 1'b0;
      end
      if (!rstn || !busy_w[k]) continue;
      got    = '0;
      stable = 1'b1;
      abort  = 1'b0;
      for (int b = 0; b < 11 && !abort; b++) begin
        for (int c = 0; c < cpb && !abort; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (!rstn) begin
            abort = 1'b1;
          end else begin
            if (!busy_w[k]) stable = 1'b0;
            if (c == 0) got[b] = tx_out_w[k];
            else if (tx_out_w[k] !== got[b]) stable = 1'b0;
          end
        end
      end
      if (abort) continue;
      @(negedge clk);
      chk($sformatf("frame_end%0d", k),
          32'({busy_w[k], done_w[k]}), 32'b01);
      chk($sformatf("bit_stable%0d", k), 32'(stable), 1);
      done_low = 1'b1;
      if (sb_size(k) == 0) begin
        chk($sformatf("frame_expected%0d", k), 32'(sb_size(k)), 1);
      end else begin
        sb_pop(k, exp);
        chk($sformatf("frame%0d", k), 32'(got), 32'(exp));
      end
    end
  endtask

  task automatic wait_done(input int k, output int cyc);
    cyc = 0;
    while (!done_w[k] && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("done_seen%0d", k), 32'(done_w[k]), 1);
  endtask

  task automatic send(input int k, input logic [7:0] d);
    start_w[k] = 1'b1;
    data_w[k]  = d;
    @(negedge clk);
    start_w[k] = 1'b0;
    chk($sformatf("accept%0d", k),
        32'({busy_w[k], tx_out_w[k]}), 32'b10);
  endtask

  initial begin
    int cyc;
    int ndone;
    tbl[0] = '{0, 8'hA5, 1'b0};
    tbl[1] = '{0, 8'h07, 1'b1};
    tbl[2] = '{1, 8'h07, 1'b0};
    tbl[3] = '{2, 8'h07, 1'b1};
    tbl[4] = '{0, 8'h00, 1'b0};
    tbl[5] = '{1, 8'h00, 1'b1};
    tbl[6] = '{0, 8'hFF, 1'b0};
    tbl[7] = '{2, 8'hA5, 1'b0};
    tbl[8] = '{1, 8'h80, 1'b0};
    tbl[9] = '{2, 8'hFF, 1'b0};

    rstn    = 1'b0;
    start_w = '0;
    for (int i = 0; i < 3; i++) data_w[i] = 8'h00;
    fork
      mon(0, 4);
      mon(1, 4);
      mon(2, 1);
    join_none

    repeat (3) @(negedge clk);
    chk("reset_state", 32'({tx_out_w, busy_w, done_w}), 32'h1C0);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", 32'({tx_out_w, busy_w, done_w}), 32'h1C0);
    end

    for (int i = 0; i < 10; i++) begin
      sb_push(tbl[i].k, frame(tbl[i].d, tbl[i].p));
      send(tbl[i].k, tbl[i].d);
      wait_done(tbl[i].k, cyc);
      repeat (2) @(negedge clk);
    end

    // back-to-back: start held high, new data in the done cycle
    sb_push(0, frame(8'h55, 1'b0));
    sb_push(0, frame(8'h0F, 1'b0));
    start_w[0] = 1'b1;
    data_w[0]  = 8'h55;
    wait_done(0, cyc);
    data_w[0] = 8'h0F;
    @(negedge clk);
    chk("b2b_restart", 32'({busy_w[0], tx_out_w[0]}), 32'b10);
    start_w[0] = 1'b0;
    wait_done(0, cyc);
    chk("b2b_gap", 32'(cyc + 1), 32'((8 + 3) * 4 + 1));
    repeat (2) @(negedge clk);

    // mid-frame start with other data is dropped
    sb_push(0, frame(8'h3C, 1'b0));
    start_w[0] = 1'b1;
    data_w[0]  = 8'h3C;
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start_w[0] = (i == 10);
      if (i == 10) data_w[0] = 8'hC3;
      if (i == 11) data_w[0] = 8'h00;
      if (done_w[0]) ndone++;
    end
    chk("ignored_start_done_cnt", 32'(ndone), 1);

    // reset during data bit 3, then a clean frame
    start_w[0] = 1'b1;
    data_w[0]  = 8'h81;
    repeat (18) @(posedge clk);
    start_w[0] = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("async_reset", 32'({tx_out_w[0], busy_w[0], done_w[0]}), 32'b100);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    sb_push(0, frame(8'h81, 1'b0));
    send(0, 8'h81);
    wait_done(0, cyc);

    repeat (5) @(negedge clk);
    chk("sb_left", 32'(sb_size(0) + sb_size(1) + sb_size(2)), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
